put_arbiter: RTL

Round-robin arbiter that shares a single Get-side consumer between NUM_PORTS Put-side producers, using the codebase's EN/RDY method handshake. Each producer advertises pending data on a request line. The arbiter grants one producer at a time and holds the grant for a whole multi-beat message, delimited by a last flag. Accepted beats pass through a 2-entry output buffer, so no RDY output depends combinationally on any EN input.

---
 rtl/put_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/put_arbiter.sv
// rtl/put_arbiter.sv - round-robin message arbiter from N put producers into one get consumer
module put_arbiter_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_idx;
    logic             rd_idx;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && (count != 2'd2);
    assign pop_ok  = pop && (count != 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_idx <= 1'b0;
            rd_idx <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem[wr_idx] <= push_data;
                wr_idx      <= ~wr_idx;
            end
            if (pop_ok) begin
                rd_idx <= ~rd_idx;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Head reads as zero when empty so the get side never shows stale beats.
    assign head = (count == 2'd0) ? '0 : mem[rd_idx];

endmodule

module put_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PORTS  = 4,
    parameter int SRC_WIDTH  = 2
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [NUM_PORTS-1:0]            REQ_put,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] put,
    input  logic [NUM_PORTS-1:0]            put_last,
    input  logic [NUM_PORTS-1:0]            EN_put,
    output logic [NUM_PORTS-1:0]            RDY_put,
    output logic [DATA_WIDTH-1:0]           get,
    output logic                            get_last,
    output logic [SRC_WIDTH-1:0]            get_src,
    input  logic                            EN_get,
    output logic                            RDY_get
);

    localparam int ENTRY_WIDTH = DATA_WIDTH + 1 + SRC_WIDTH;

    typedef enum logic {
        ARB,
        GRANT
    } state_t;

    state_t                 fsm;
    logic [SRC_WIDTH-1:0]   g;
    logic [SRC_WIDTH-1:0]   ptr;
    logic [SRC_WIDTH-1:0]   arb_sel;
    logic [1:0]             cnt;
    logic                   not_full;
    logic                   push;
    logic                   pop;
    logic [ENTRY_WIDTH-1:0] push_entry;
    logic [ENTRY_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0]  put_arr [NUM_PORTS];

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
        assign put_arr[i] = put[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign not_full   = (cnt != 2'd2);
    assign push       = (fsm == GRANT) && not_full && EN_put[g];
    assign pop        = EN_get && RDY_get;
    assign push_entry = {put_arr[g], put_last[g], g};

    // Scan from the far end so the requester nearest after ptr overwrites the rest.
    always_comb begin
        arb_sel = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            if (REQ_put[SRC_WIDTH'((int'(ptr) + k) % NUM_PORTS)]) begin
                arb_sel = SRC_WIDTH'((int'(ptr) + k) % NUM_PORTS);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fsm <= ARB;
            g   <= '0;
            ptr <= SRC_WIDTH'(NUM_PORTS - 1);
        end else begin
            case (fsm)
                ARB: begin
                    if ((|REQ_put) && not_full) begin
                        g   <= arb_sel;
                        fsm <= GRANT;
                    end
                end
                GRANT: begin
                    // The grant is held until the last beat, whatever REQ_put does meanwhile.
                    if (push && put_last[g]) begin
                        ptr <= g;
                        fsm <= ARB;
                    end
                end
                default: fsm <= ARB;
            endcase
        end
    end

    always_comb begin
        RDY_put = '0;
        if ((fsm == GRANT) && not_full) begin
            RDY_put[g] = 1'b1;
        end
    end

    put_arbiter_fifo2 #(
        .WIDTH(ENTRY_WIDTH)
    ) u_buf (
        .clk      (CLK),
        .rst      (RST),
        .push     (push),
        .push_data(push_entry),
        .pop      (pop),
        .head     (head),
        .count    (cnt)
    );

    assign RDY_get  = (cnt != 2'd0);
    assign get_src  = head[SRC_WIDTH-1:0];
    assign get_last = head[SRC_WIDTH];
    assign get      = head[SRC_WIDTH+1 +: DATA_WIDTH];

endmodule
